// File: rtl/pipe_adder.sv
// Chunked, fully registered add/subtract pipeline with a single global stall.
// Each stage resolves one C-bit chunk. Unused operand chunks and finished result chunks travel alongside it.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int C = WIDTH / STAGES;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipe_adder: WIDTH must be a positive integer multiple of STAGES");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             advance;

  // Subtraction is a + ~b + ~cin, so a borrow-in of 1 becomes a carry-in of 0.
  assign b_eff    = op ? ~b : b;
  assign cin_eff  = op ? ~cin : cin;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int OW = WIDTH - k * C;
    localparam int RW = (k + 1) * C;

    logic [OW-1:0] a_in;
    logic [OW-1:0] b_in;
    logic          cy_in;
    logic          vld_in;
    logic [C:0]    part;
    logic [RW-1:0] res_nxt;
    logic [RW-1:0] res_q;
    logic          cy_q;
    logic          vld_q;

    if (k == 0) begin : g_head
      assign a_in    = a;
      assign b_in    = b_eff;
      assign cy_in   = cin_eff;
      assign vld_in  = in_valid;
      assign res_nxt = part[C-1:0];
    end else begin : g_body
      assign a_in    = g_stage[k-1].g_fwd.a_q;
      assign b_in    = g_stage[k-1].g_fwd.b_q;
      assign cy_in   = g_stage[k-1].cy_q;
      assign vld_in  = g_stage[k-1].vld_q;
      assign res_nxt = {part[C-1:0], g_stage[k-1].res_q};
    end

    // The carry chain stops at the chunk boundary; the carry-out is registered.
    assign part = {1'b0, a_in[C-1:0]} + {1'b0, b_in[C-1:0]} + {{C{1'b0}}, cy_in};

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        vld_q <= vld_in;
        cy_q  <= part[C];
        res_q <= res_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [OW-C-1:0] a_q;
      logic [OW-C-1:0] b_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[OW-1:C];
          b_q <= b_in[OW-1:C];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // The top chunk still carries both operand sign bits (b already inverted for subtract).
      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (a_in[C-1] == b_in[C-1]) && (part[C-1] != a_in[C-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = {g_stage[STAGES-1].cy_q, g_stage[STAGES-1].res_q};
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: expected results are queued on input transfer
// and compared on output transfer; scenario tasks add latency, stall and reset checks.
module tb_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  logic [WIDTH+1:0] sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_in     = 0;
  int n_out    = 0;

  // Reference: {ovf, carry/no-borrow, result} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c, input logic o);
    longint ux, uy, sx, sy, cc, r;
    logic [63:0]    raw;
    logic [WIDTH:0] s;
    logic           v;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    cc = longint'(c);
    if (!o) begin
      raw = ux + uy + cc;
      s   = raw[WIDTH:0];
      r   = sx + sy + cc;
    end else begin
      raw = ux - uy - cc;
      s   = {(ux >= uy + cc), raw[WIDTH-1:0]};
      r   = sx - sy - cc;
    end
    v = (r > longint'(2**(WIDTH-1) - 1)) || (r < -longint'(2**(WIDTH-1)));
    return {v, s};
  endfunction

  // One clock: scoreboard work at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    logic [WIDTH+1:0] exp_v;
    @(negedge clk);
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_extra: got sum=%h ovf=%b, required no output", sum, ovf);
        end else begin
          exp_v = sb_q.pop_front();
          n_out++;
          if ({ovf, sum} !== exp_v) begin
            n_fail++;
            $display("FAIL scoreboard_result: got sum=%h ovf=%b, required sum=%h ovf=%b",
                     sum, ovf, exp_v[WIDTH:0], exp_v[WIDTH+1]);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(a, b, cin, op));
        n_in++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_operands();
    a   = WIDTH'($urandom);
    b   = WIDTH'($urandom);
    cin = 1'($urandom_range(0, 1));
    op  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((sb_q.size() != 0 || out_valid !== 1'b0) && guard < 4 * STAGES) begin
      tick();
      guard++;
    end
    n_checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: pending=%0d out_valid=%b, required pending=0 out_valid=0",
               name, sb_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'h1234; b = 16'h1111; cin = 1'b0; op = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_checks++;
    if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h, required 0", sum); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
    reset = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    for (int i = 0; i < STAGES + 2; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_input_rejected: cycle %0d out_valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_directed(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic c, input logic o, input logic [WIDTH:0] exp_sum, input logic exp_ovf);
    out_ready = 1'b1;
    a = x; b = y; cin = c; op = o; in_valid = 1'b1;
    for (int e = 1; e <= STAGES; e++) begin
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== (e == STAGES)) begin
        n_fail++;
        $display("FAIL %s_latency: after edge %0d out_valid=%b, required %b", name, e, out_valid, (e == STAGES));
      end
    end
    n_checks++;
    if (sum !== exp_sum || ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s: got sum=%h ovf=%b, required sum=%h ovf=%b", name, sum, ovf, exp_sum, exp_ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int e = 1; e <= 8 + STAGES; e++) begin
      in_valid = (e <= 8);
      rand_operands();
      tick();
      n_checks++;
      if (out_valid !== ((e >= STAGES) && (e <= STAGES + 7))) begin
        n_fail++;
        $display("FAIL back_to_back: after edge %0d out_valid=%b, required %b",
                 e, out_valid, ((e >= STAGES) && (e <= STAGES + 7)));
      end
    end
    wait_drain("back_to_back_drain");
  endtask

  task automatic test_stall();
    logic [WIDTH:0] held;
    int base_out;
    base_out  = n_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      rand_operands();
      tick();
    end
    held = sum;
    for (int s = 0; s < 5; s++) begin
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: cycle %0d got %b, required 0", s, in_ready); end
      n_checks++;
      if (out_valid !== 1'b1 || sum !== held) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d out_valid=%b sum=%h, required 1 and %h", s, out_valid, sum, held);
      end
      rand_operands();
      tick();
    end
    wait_drain("stall_drain");
    n_checks++;
    if (n_out - base_out != STAGES) begin
      n_fail++; $display("FAIL stall_count: got %0d results, required %0d", n_out - base_out, STAGES);
    end
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_operands();
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2 * STAGES; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_midop: cycle %0d out_valid=%b, required 0", i, out_valid);
      end
      tick();
    end
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL reset_midop_flush: pending=%0d, required 0", sb_q.size()); end
  endtask

  task automatic test_random();
    int base_in, base_out, guard;
    logic [WIDTH:0] prev_sum;
    logic prev_ovf, stalled;
    base_in = n_in; base_out = n_out; guard = 0;
    while (n_in - base_in < 1000 && guard < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_operands();
      stalled  = out_valid && !out_ready;
      prev_sum = sum;
      prev_ovf = ovf;
      tick();
      guard++;
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || sum !== prev_sum || ovf !== prev_ovf) begin
          n_fail++;
          $display("FAIL random_stall_hold: out_valid=%b sum=%h ovf=%b, required 1 %h %b",
                   out_valid, sum, ovf, prev_sum, prev_ovf);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_in - base_in != 1000) begin
      n_fail++; $display("FAIL random_inputs: got %0d transfers, required 1000", n_in - base_in);
    end
    wait_drain("random_drain");
    n_checks++;
    if (n_out - base_out != 1000) begin
      n_fail++; $display("FAIL random_count: got %0d results, required 1000", n_out - base_out);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;
    test_reset();
    test_directed("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0);
    test_directed("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1);
    test_directed("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1);
    test_directed("sub_borrow",  16'h0003, 16'h0005, 1'b1, 1'b1, 17'h0FFFD, 1'b0);
    test_back_to_back();
    test_stall();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
